// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back stage and its optional load aligner.
// The aligner is built only when WB_LOAD_ALIGN_EN is defined.
package wb_pkg;
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    localparam int SRC_PC4 = 0;
    localparam int SRC_ALU = 1;
    localparam int SRC_FPU = 2;
    localparam int SRC_MEM = 3;
    typedef enum logic {WB_ONE = 1'b0, WB_PAIR = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: big-endian sub-word extraction with zero/sign extension.
module wb_load_align import wb_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] aligned
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        // Offset 0 is the most significant byte; halves ignore offset bit 0.
        byte_v  = word[DATA_W-8-8*int'(off) +: 8];
        half_v  = word[DATA_W-16-8*int'(off & 2'b10) +: 16];
        aligned = size == LS_HALF ? {{(DATA_W-16){is_signed & half_v[15]}}, half_v}
                : size == LS_BYTE ? {{(DATA_W-8){is_signed & byte_v[7]}}, byte_v}
                : word;
    end
endmodule

// File: rtl/write_back_pipe.sv
// write_back_pipe: MEM/WB stage register and register-file write port with two-beat pair writes.
// Define WB_LOAD_ALIGN_EN to enable sub-word load alignment on the MEM_SRC slice.
module write_back_pipe import wb_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int NSRC    = 4,
    parameter int SEL_W   = 2,
    parameter int MEM_SRC = SRC_MEM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   NextValid,
    input  logic [NSRC*DATA_W-1:0] NextSrcData,
    input  logic [SEL_W-1:0]       NextDInSrc,
    input  logic                   NextRegWE,
    input  logic [ADDR_W-1:0]      NextRegWAddr,
    input  logic                   NextDouble,
    input  logic [DATA_W-1:0]      NextPairData,
    input  logic [1:0]             NextLoadSize,
    input  logic                   NextLoadSigned,
    input  logic [1:0]             NextByteOff,
    output logic                   Busy,
    output logic                   RegWBWE,
    output logic [ADDR_W-1:0]      RegWBAddr,
    output logic [DATA_W-1:0]      RegWBData
);
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   dbl;
        logic [SEL_W-1:0]       sel;
        logic [ADDR_W-1:0]      addr;
        logic [NSRC*DATA_W-1:0] src;
        logic [DATA_W-1:0]      pair;
`ifdef WB_LOAD_ALIGN_EN
        logic [1:0]             lsize;
        logic                   lsigned;
        logic [1:0]             off;
`endif
    } stage_t;

    stage_t    stage_q, stage_d;
    wb_state_e state_q, state_d;
    logic [DATA_W-1:0] sel_data, mem_data;

    assign Busy      = state_q == WB_ONE && stage_q.valid && stage_q.we && stage_q.dbl;
    assign RegWBWE   = stage_q.valid & stage_q.we;
    assign RegWBAddr = state_q == WB_PAIR ? stage_q.addr | ADDR_W'(1) : stage_q.addr;
    assign RegWBData = state_q == WB_PAIR ? stage_q.pair
                     : int'(stage_q.sel) == MEM_SRC ? mem_data : sel_data;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++)
            if (int'(stage_q.sel) == k) sel_data = stage_q.src[(NSRC-1-k)*DATA_W +: DATA_W];
    end

`ifdef WB_LOAD_ALIGN_EN
    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .word      (sel_data),
        .size      (stage_q.lsize),
        .is_signed (stage_q.lsigned),
        .off       (stage_q.off),
        .aligned   (mem_data)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{NextLoadSize, NextLoadSigned, NextByteOff};
    assign mem_data  = sel_data;
`endif

    always_comb begin
        stage_d = stage_q;
        state_d = WB_ONE;
        // While the first beat is out nothing is captured; the pair beat always accepts.
        if (Busy) state_d = WB_PAIR;
        else if (Stall || Flush) begin
            stage_d.valid = 1'b0;
            stage_d.we    = 1'b0;
        end else begin
            stage_d.valid = NextValid;
            stage_d.we    = NextRegWE;
            stage_d.dbl   = NextDouble;
            stage_d.sel   = NextDInSrc;
            stage_d.addr  = NextRegWAddr;
            stage_d.src   = NextSrcData;
            stage_d.pair  = NextPairData;
`ifdef WB_LOAD_ALIGN_EN
            stage_d.lsize   = NextLoadSize;
            stage_d.lsigned = NextLoadSigned;
            stage_d.off     = NextByteOff;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WB_ONE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end
endmodule

// File: tb/tb_write_back_pipe.sv
// tb_write_back_pipe: directed and random checks of write_back_pipe against a beat-queue model.
module tb_write_back_pipe;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         Stall, Flush, NextValid, NextRegWE, NextDouble, NextLoadSigned;
    logic [127:0] NextSrcData;
    logic [1:0]   NextDInSrc, NextLoadSize, NextByteOff;
    logic [5:0]   NextRegWAddr;
    logic [31:0]  NextPairData;
    logic         Busy, RegWBWE, busy2, we2;
    logic [5:0]   RegWBAddr, addr2;
    logic [31:0]  RegWBData, data2;
    int checks = 0;
    int failures = 0;

    write_back_pipe dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .NextValid(NextValid),
        .NextSrcData(NextSrcData), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
        .NextRegWAddr(NextRegWAddr), .NextDouble(NextDouble), .NextPairData(NextPairData),
        .NextLoadSize(NextLoadSize), .NextLoadSigned(NextLoadSigned), .NextByteOff(NextByteOff),
        .Busy(Busy), .RegWBWE(RegWBWE), .RegWBAddr(RegWBAddr), .RegWBData(RegWBData)
    );

    write_back_pipe #(.NSRC(3), .SEL_W(2), .MEM_SRC(2)) dut3 (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .NextValid(NextValid),
        .NextSrcData(NextSrcData[95:0]), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
        .NextRegWAddr(NextRegWAddr), .NextDouble(NextDouble), .NextPairData(NextPairData),
        .NextLoadSize(NextLoadSize), .NextLoadSigned(NextLoadSigned), .NextByteOff(NextByteOff),
        .Busy(busy2), .RegWBWE(we2), .RegWBAddr(addr2), .RegWBData(data2)
    );

    typedef struct {
        logic        busy;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        zero;
    } beat_t;

    beat_t cur = '{busy: 1'b0, we: 1'b0, addr: 6'd0, data: 32'd0, zero: 1'b1};
    beat_t pend[$];

    function automatic logic [31:0] load_value(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] off);
        logic [31:0] r;
        r = w;
`ifdef WB_LOAD_ALIGN_EN
        if (sz == 2'b10) begin
            r = (w >> (24 - 8 * int'(off))) & 32'hFF;
            if (sg && r[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            r = off[1] ? (w & 32'hFFFF) : (w >> 16);
            if (sg && r[15]) r = r | 32'hFFFF_0000;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] expected_data();
        logic [31:0] w;
        w = NextSrcData[(3 - int'(NextDInSrc)) * 32 +: 32];
        return NextDInSrc == 2'd3 ? load_value(w, NextLoadSize, NextLoadSigned, NextByteOff) : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic take;
        if (!reset) begin
            cur = '{busy: 1'b0, we: 1'b0, addr: 6'd0, data: 32'd0, zero: 1'b1};
            pend.delete();
        end else if (cur.busy) begin
            cur = pend.pop_front();
        end else begin
            take = NextValid && NextRegWE && !Stall && !Flush;
            if (take && NextDouble) begin
                cur = '{busy: 1'b1, we: 1'b1, addr: NextRegWAddr, data: expected_data(), zero: 1'b0};
                pend.push_back('{busy: 1'b0, we: 1'b1, addr: NextRegWAddr | 6'd1, data: NextPairData, zero: 1'b0});
            end else
                cur = '{busy: 1'b0, we: take, addr: NextRegWAddr, data: expected_data(), zero: 1'b0};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(Busy), 32'(cur.busy));
        chk("we", 32'(RegWBWE), 32'(cur.we));
        if (cur.we || cur.zero) begin
            chk("addr", 32'(RegWBAddr), 32'(cur.addr));
            chk("data", RegWBData, cur.data);
        end
    endtask

    task automatic entry(input logic v, input logic we, input logic [1:0] sel, input logic [5:0] a,
                         input logic dbl, input logic [31:0] pr);
        NextValid = v; NextRegWE = we; NextDInSrc = sel; NextRegWAddr = a;
        NextDouble = dbl; NextPairData = pr; Stall = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        NextSrcData = '0; NextLoadSize = 2'b00; NextLoadSigned = 1'b0; NextByteOff = 2'b00;
        entry(1'b1, 1'b1, 2'd1, 6'd9, 1'b0, 32'h0);
        step();
        step();
        chk("reset_data", RegWBData, 32'h0);
        reset = 1'b1;

        NextSrcData = {32'h0000_0004, 32'h0000_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        entry(1'b1, 1'b1, 2'd1, 6'd5, 1'b0, 32'h0);
        step();
        chk("single_data", RegWBData, 32'h0000_1234);
        chk("single_addr", 32'(RegWBAddr), 32'd5);

        NextSrcData = {96'h0, 32'h12F3_5678};
        entry(1'b1, 1'b1, 2'd3, 6'd7, 1'b0, 32'h0);
        NextLoadSize = 2'b10; NextLoadSigned = 1'b1; NextByteOff = 2'd1;
        step();
`ifdef WB_LOAD_ALIGN_EN
        chk("byte_signed", RegWBData, 32'hFFFF_FFF3);
`else
        chk("mem_passthru", RegWBData, 32'h12F3_5678);
`endif
        NextLoadSize = 2'b01; NextLoadSigned = 1'b0; NextByteOff = 2'd2;
        step();
`ifdef WB_LOAD_ALIGN_EN
        chk("half_unsigned", RegWBData, 32'h0000_5678);
`endif

        NextSrcData = {32'h0, 32'h0, 32'h4009_21FB, 32'h0};
        entry(1'b1, 1'b1, 2'd2, 6'd34, 1'b1, 32'h5444_2D18);
        step();
        chk("dbl_busy1", 32'(Busy), 32'd1);
        NextSrcData = {32'h0, 32'h0000_0077, 64'h0};
        entry(1'b1, 1'b1, 2'd1, 6'd9, 1'b0, 32'h0);
        Flush = 1'b1;
        step();
        chk("dbl_beat2_addr", 32'(RegWBAddr), 32'd35);
        chk("dbl_beat2_data", RegWBData, 32'h5444_2D18);
        Flush = 1'b0;
        step();
        chk("after_dbl_addr", 32'(RegWBAddr), 32'd9);

        entry(1'b1, 1'b1, 2'd1, 6'd11, 1'b0, 32'h0);
        Stall = 1'b1;
        step();
        chk("stall_we", 32'(RegWBWE), 32'd0);
        Stall = 1'b1; Flush = 1'b1;
        step();

        entry(1'b1, 1'b1, 2'd2, 6'd40, 1'b1, 32'h1111_2222);
        step();
        reset = 1'b0;
        step();
        chk("rst_pair_we", 32'(RegWBWE), 32'd0);
        reset = 1'b1;
        entry(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 32'h0);
        step();

        NextSrcData = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        NextLoadSize = 2'b00;
        entry(1'b1, 1'b1, 2'd3, 6'd3, 1'b0, 32'h0);
        step();
        chk("nsrc3_sel3", data2, 32'h0);
        entry(1'b1, 1'b1, 2'd1, 6'd3, 1'b0, 32'h0);
        step();
        chk("nsrc3_sel1", data2, 32'hCCCC_0003);

        for (int i = 0; i < 400; i++) begin
            NextSrcData = {$urandom, $urandom, $urandom, $urandom};
            NextValid = $urandom_range(0, 9) != 0;
            NextRegWE = $urandom_range(0, 7) != 0;
            NextDouble = $urandom_range(0, 3) == 0;
            NextDInSrc = 2'($urandom_range(0, 3));
            NextRegWAddr = 6'($urandom);
            if (NextDouble) NextRegWAddr[0] = 1'b0;
            NextPairData = $urandom;
            NextLoadSize = 2'($urandom);
            NextLoadSigned = 1'($urandom);
            NextByteOff = 2'($urandom);
            Stall = $urandom_range(0, 9) == 0;
            Flush = $urandom_range(0, 11) == 0;
            reset = $urandom_range(0, 49) != 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
